// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial unsigned subtractor, diff = a - b, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_abit;
  logic             w_bbit;
  logic             w_dbit;
  logic             w_br_next;

  // One full-subtractor slice, fed from the operand shift registers' LSBs.
  assign w_abit    = a_sr_q[0];
  assign w_bbit    = b_sr_q[0];
  assign w_dbit    = w_abit ^ w_bbit ^ br_q;
  assign w_br_next = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & br_q);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    br_d    = br_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {w_dbit, diff_q[WIDTH-1:1]};
        br_d   = w_br_next;
        // Counter holds on the final slice so it never wraps inside a run.
        if (cnt_q == CNT_LAST) begin
          zero_d  = (diff_d == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = br_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed + randomised checks of serial_subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH;
  localparam int BOUND = 40;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  int errors;
  int checks;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b,
                        input logic exp_z, input int stall, input bit toggle);
    int cyc;
    logic [WIDTH-1:0] held_d;
    logic             held_b;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc <= BOUND) begin
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        check("in_ready_run", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(LAT));
    if (out_valid) begin
      check("diff", 32'(diff), 32'(exp_d));
      check("borrow", 32'(borrow), 32'(exp_b));
      check("zero", 32'(zero), 32'(exp_z));
      held_d = diff;
      held_b = borrow;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_diff", 32'(diff), 32'(held_d));
        check("stall_borrow", 32'(borrow), 32'(held_b));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("valid_after_take", 32'(out_valid), 32'd0);
      check("ready_after_take", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    int stall;
    errors    = 0;
    checks    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 5, 1'b0);
    run_op(8'hA5, 8'h3C, 8'h69, 1'b0, 1'b0, 2, 1'b1);

    // Reset asserted mid-run must clear outputs without waiting for a clock.
    a        = 8'h12;
    b        = 8'h34;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_diff", 32'(diff), 32'd0);
    check("midrun_rst_borrow", 32'(borrow), 32'd0);
    check("midrun_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra    = WIDTH'($urandom);
      rb    = WIDTH'($urandom);
      rd    = ra - rb;
      stall = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      run_op(ra, rb, rd, (ra < rb), (rd == '0), stall, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
